// File: rtl/axis_frame_sink_pkg.sv
// Shared types and helpers for axis_frame_sink: FSM state encoding, default
// sizing constants and a saturating counter increment.
package axis_frame_sink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam int unsigned DEF_FRAME_LEN  = 512;
  localparam int unsigned DEF_STAT_WIDTH = 16;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/axis_frame_sink.sv
// AXI-Stream frame sink: writes beats into a FIFO port, marks frame starts and
// checks frame length. Length check / DROP state enabled by AXIS_FRAME_SINK_LEN_CHECK_EN.
module axis_frame_sink
  import axis_frame_sink_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned KEEP_WIDTH = 1,
  parameter int unsigned FRAME_LEN  = DEF_FRAME_LEN,
  parameter int unsigned CNT_WIDTH  = 10,
  parameter int unsigned STAT_WIDTH = DEF_STAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  output logic                  o_fifo_wr,
  output logic [DATA_WIDTH-1:0] o_fifo_data,
  output logic                  o_fifo_sof,
  input  logic                  i_fifo_full,
  output logic                  o_frame_done,
  output logic                  o_err_short,
  output logic                  o_err_long,
  output logic [STAT_WIDTH-1:0] o_frame_cnt,
  output logic [STAT_WIDTH-1:0] o_err_cnt
);

  localparam logic [CNT_WIDTH-1:0] LEN_C = CNT_WIDTH'(FRAME_LEN);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d, n;
  logic                    wr_d, sof_d, done_d, short_d, long_d;
  logic [DATA_WIDTH-1:0]   data_d;
  logic [STAT_WIDTH-1:0]   frame_cnt_d, err_cnt_d;
  logic                    accept;
  logic                    unused_tkeep;

  assign unused_tkeep  = ^s_axis_tkeep;
  // FIFO headroom absorbs the beat accepted in the cycle full rises.
  assign s_axis_tready = ~rst & ((state_q == ST_DROP) | ~i_fifo_full);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign n             = cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      o_fifo_wr    <= 1'b0;
      o_fifo_data  <= '0;
      o_fifo_sof   <= 1'b0;
      o_frame_done <= 1'b0;
      o_err_short  <= 1'b0;
      o_err_long   <= 1'b0;
      o_frame_cnt  <= '0;
      o_err_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      o_fifo_wr    <= wr_d;
      o_fifo_data  <= data_d;
      o_fifo_sof   <= sof_d;
      o_frame_done <= done_d;
      o_err_short  <= short_d;
      o_err_long   <= long_d;
      o_frame_cnt  <= frame_cnt_d;
      o_err_cnt    <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    data_d  = o_fifo_data;
    sof_d   = 1'b0;
    done_d  = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
`ifdef AXIS_FRAME_SINK_LEN_CHECK_EN
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wr_d   = 1'b1;
          data_d = s_axis_tdata;
          sof_d  = 1'b1;
          cnt_d  = CNT_WIDTH'(1);
          if (s_axis_tlast) begin
            done_d  = (FRAME_LEN == 1);
            short_d = (FRAME_LEN != 1);
            cnt_d   = '0;
          end else if (FRAME_LEN == 1) begin
            long_d  = 1'b1;
            state_d = ST_DROP;
          end else begin
            state_d = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (accept) begin
          wr_d   = 1'b1;
          data_d = s_axis_tdata;
          cnt_d  = n;
          if (s_axis_tlast) begin
            done_d  = (n == LEN_C);
            short_d = (n != LEN_C);
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else if (n == LEN_C) begin
            long_d  = 1'b1;
            state_d = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (accept && s_axis_tlast) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
`else
    // Without length checking the count only identifies the first word of a frame.
    if (accept) begin
      wr_d   = 1'b1;
      data_d = s_axis_tdata;
      sof_d  = (cnt_q == '0);
      done_d = s_axis_tlast;
      cnt_d  = s_axis_tlast ? '0 : ((cnt_q == LEN_C) ? cnt_q : n);
    end
`endif
    frame_cnt_d = done_d ? STAT_WIDTH'(sat_inc(32'(o_frame_cnt), STAT_WIDTH)) : o_frame_cnt;
    err_cnt_d   = (short_d | long_d) ? STAT_WIDTH'(sat_inc(32'(o_err_cnt), STAT_WIDTH))
                                     : o_err_cnt;
  end

endmodule

// File: doc/axis_frame_sink.md
# axis_frame_sink

AXI-Stream slave that terminates the fixed-length frame stream from the DMA path. It accepts beats, writes each word into a downstream FIFO write port, marks frame starts, and checks every frame against the fixed length `FRAME_LEN`. It reports good frames and short or long frames through pulses and saturating counters. It sits between an AXI-Stream master (DMA MM2S or a loopback) and the LVDS/SPI transmit FIFO.

## Interface
Parameters:
- `DATA_WIDTH`, 32: tdata and FIFO word width in bits
- `KEEP_WIDTH`, 1: tkeep width; input accepted, ignored
- `FRAME_LEN`, 512: expected beats per frame, ≥1
- `CNT_WIDTH`, 10: word counter width; must hold `FRAME_LEN`
- `STAT_WIDTH`, 16: width of frame and error counters

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `s_axis_tvalid` in 1: beat valid
- `s_axis_tready` out 1: beat ready
- `s_axis_tdata` in `DATA_WIDTH`: beat data
- `s_axis_tkeep` in `KEEP_WIDTH`: ignored
- `s_axis_tlast` in 1: last beat of frame
- `o_fifo_wr` out 1: FIFO write strobe, one word per cycle
- `o_fifo_data` out `DATA_WIDTH`: FIFO write data
- `o_fifo_sof` out 1: qualifies `o_fifo_wr`; word is the first of a frame
- `i_fifo_full` in 1: FIFO almost-full, with at least one word of headroom
- `o_frame_done` out 1: one-cycle pulse, correct-length frame completed
- `o_err_short` out 1: one-cycle pulse, tlast before `FRAME_LEN` beats
- `o_err_long` out 1: one-cycle pulse, `FRAME_LEN` beats without tlast
- `o_frame_cnt` out `STAT_WIDTH`: good frames, saturating
- `o_err_cnt` out `STAT_WIDTH`: short plus long errors, saturating

## Operation
- Beat accepted when `s_axis_tvalid & s_axis_tready`.
- `s_axis_tready` is 0 in reset. Outside DROP it is `~i_fifo_full`, combinational. In DROP it is 1.
- `word_cnt` holds the number of beats accepted in the current frame. In the rules below, `n = word_cnt + 1` for the beat being accepted.
- State IDLE (reset state), on an accepted beat:
  - Write the word with sof=1; `word_cnt` ← 1.
  - tlast=1 and `FRAME_LEN`=1: frame_done, stay IDLE.
  - tlast=1 and `FRAME_LEN`>1: err_short, stay IDLE.
  - Otherwise go to RECV. If `FRAME_LEN`=1, this is a long error: err_long, go to DROP.
- State RECV, on an accepted beat:
  - Write the word; `word_cnt` ← n.
  - tlast=1 and n=`FRAME_LEN`: frame_done, go IDLE.
  - tlast=1 and n<`FRAME_LEN`: err_short, go IDLE. Words already written stay in the FIFO.
  - tlast=0 and n=`FRAME_LEN`: err_long, go DROP. This beat is still written.
- State DROP: accept and discard beats with no FIFO write. On tlast go IDLE.
- Counters: `o_frame_cnt` +1 per frame_done; `o_err_cnt` +1 per short or long error. Both saturate at all-ones; no wrap.
- `word_cnt` never exceeds `FRAME_LEN` and is cleared on entry to IDLE.

## Timing
- Reset values: all outputs 0, both counters 0, `word_cnt` 0, state IDLE.
- `rst` asserted mid-frame: state, data and counters cleared immediately. The first beat after release is treated as a frame start.
- Latency: a beat accepted in cycle t gives `o_fifo_wr`/`o_fifo_data`/`o_fifo_sof` registered in cycle t+1.
- frame_done and error pulses are registered and appear in cycle t+1, coincident with the write of the deciding beat.
- Throughput: one beat per cycle while not full.
- `i_fifo_full` rising in the cycle of an accepted beat: the headroom absorbs that beat's write. No word is lost or duplicated.
- tvalid low mid-frame: state holds indefinitely; there is no timeout.

## Configuration
- `AXIS_FRAME_SINK_LEN_CHECK_EN` defined: full IDLE/RECV/DROP behaviour as above.
- Not defined:
  - No length check and no DROP state.
  - Every accepted beat is written; tlast ends the frame and pulses `o_frame_done`.
  - `o_err_short`, `o_err_long` and `o_err_cnt` are tied to 0.
  - `word_cnt` still counts beats, but only to drive sof.

## Structure
- Shared package `axis_frame_sink_pkg` holds:
  - state enum (IDLE, RECV, DROP)
  - default `FRAME_LEN` and `STAT_WIDTH` constants
  - a saturating-increment function
- No sub-module is needed; a single module is expected to be under 250 lines.

## Test plan
All scenarios use `FRAME_LEN`=4.
- Beats 0x10..0x13, tlast on 0x13 → four writes in order, sof only on 0x10, one frame_done, `o_frame_cnt`=1, `o_err_cnt`=0.
- Beats 0x20..0x22, tlast on 0x22 → three writes, `o_err_short` pulse, `o_err_cnt`=1. A following good 4-beat frame is written with sof on its first word.
- Beats 0x30..0x35, tlast on 0x35 → writes of 0x30..0x33 only, `o_err_long` pulse with the 0x33 write, 0x34/0x35 accepted with tready=1, state back in IDLE.
- `i_fifo_full` high for 5 cycles after beat 2 → tready 0 during the stall, the 4 words arrive intact and in order, frame_done once.
- `rst` pulse after beat 2, then a new 4-beat frame → outputs 0 during reset, new frame sof on its first word, frame_done, `o_frame_cnt`=1.
- Built without `AXIS_FRAME_SINK_LEN_CHECK_EN`: 6-beat frame → 6 writes, frame_done on the 6th, no error pulses.
